raster_pattern_source: RTL and testbench
========================================

RASTER_PATTERN_SOURCE -- requirements
Module: raster_pattern_source

Interface
REQ-001 Parameter H_RES, default 640, pixels per line (>=2).
REQ-002 Parameter V_RES, default 480, lines per frame (>=2).
REQ-003 Parameter COLOR_W, default 3, bits per pixel colour.
REQ-004 Parameter BAR_LOG2, default 6, log2 of bar width and checker cell size in pixels.
REQ-005 Derived XW = clog2(H_RES), YW = clog2(V_RES); FW = 8 (frame counter width).
REQ-006 clk_input  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  begin a frame when IDLE; ignored otherwise.
REQ-009 abort  input  1  terminate the frame in progress.
REQ-010 continuous  input  1  re-arm automatically after each frame.
REQ-011 mode  input  2  pattern select: 0 solid, 1 bars, 2 checker, 3 diagonal.
REQ-012 fill_color  input  COLOR_W  colour for mode 0.
REQ-013 read_rast_pixel_rdy  input  1  framebuffer accepts the current pixel.
REQ-014 rast_pixel_rdy  output  1  pixel valid.
REQ-015 rast_color_input  output  COLOR_W  pixel colour.
REQ-016 rast_width  output  XW  pixel x coordinate.
REQ-017 rast_height  output  YW  pixel y coordinate.
REQ-018 rast_done  output  1  one-cycle end-of-frame pulse.
REQ-019 next_frame_switch  output  1  one-cycle buffer-swap request.
REQ-020 busy  output  1  high in any state other than IDLE.
REQ-021 frame_cnt  output  FW  completed frames, wraps 255->0.

Function
REQ-022 States IDLE, STREAM, DONE, SWITCH; all outputs registered.
REQ-023 IDLE + start -> STREAM next cycle: x=0, y=0, rast_pixel_rdy=1; mode and fill_color latched then and held for the frame.
REQ-024 Transfer = cycle with rast_pixel_rdy=1 and read_rast_pixel_rdy=1; coordinates and colour hold stable until transfer.
REQ-025 On transfer: x increments; at x=H_RES-1, x->0 and y increments; valid stays high (one pixel per cycle max throughput).
REQ-026 Transfer at x=H_RES-1, y=V_RES-1 -> DONE: rast_pixel_rdy=0, rast_done=1 for exactly one cycle.
REQ-027 DONE -> SWITCH unconditionally: next_frame_switch=1 one cycle, frame_cnt increments.
REQ-028 SWITCH -> STREAM (x=y=0, mode re-latched) if continuous=1, else IDLE.
REQ-029 Colour, computed from next coordinates, aligned with them: mode 0 fill_color; mode 1 (x>>BAR_LOG2)+frame_cnt; mode 2 all bits = x[BAR_LOG2]^y[BAR_LOG2]; mode 3 x+y+frame_cnt; sums truncated to COLOR_W LSBs.
REQ-030 abort in STREAM or DONE -> IDLE next cycle, rast_pixel_rdy=0, no rast_done/next_frame_switch, frame_cnt unchanged; abort beats transfer in the same cycle.
REQ-031 abort in SWITCH: pulse completes, then IDLE regardless of continuous.
REQ-032 start and abort both high in IDLE -> stay IDLE.
REQ-033 start while busy has no effect.

Reset
REQ-034 rst asserted at any time, including mid-frame -> IDLE immediately; rast_pixel_rdy, rast_done, next_frame_switch, busy = 0; rast_width, rast_height, rast_color_input, frame_cnt = 0.
REQ-035 First start after rst deassertion is honoured on the next clock edge.

Verification (H_RES=4, V_RES=2, COLOR_W=3, BAR_LOG2=1)
REQ-036 mode 0, fill 5, ready always 1, start pulse -> 8 consecutive pixels (0,0)..(3,1) colour 5, rast_done then next_frame_switch on following cycles, frame_cnt=1, IDLE.
REQ-037 mode 1, ready toggling 1/0 -> each coordinate held until accepted, colours 0,0,1,1 per line, 8 transfers in 16 cycles.
REQ-038 continuous=1, mode 3, three frames -> frame_cnt 1,2,3; frame 2 pixel (0,0) colour 1; one-cycle gap per SWITCH and DONE each.
REQ-039 abort at pixel (2,0) with ready=1 -> that pixel not counted, no rast_done, frame_cnt unchanged, IDLE.
REQ-040 rst asserted at pixel (1,1) -> all outputs zero asynchronously; subsequent start begins at (0,0).
REQ-041 start asserted while STREAM in mode 2 -> ignored; checker colours 0,0,7,7 on line 0, 0,0,7,7 on line 1.

Source files
------------

// File: rtl/raster_pattern_source_if.sv
// Pixel stream between the raster pattern source (master) and the framebuffer (slave).
interface raster_pattern_source_if #(
    parameter int COLOR_W = 3,
    parameter int XW      = 10,
    parameter int YW      = 9
);
    logic               rast_pixel_rdy;
    logic [COLOR_W-1:0] rast_color_input;
    logic [XW-1:0]      rast_width;
    logic [YW-1:0]      rast_height;
    logic               read_rast_pixel_rdy;

    modport master (
        output rast_pixel_rdy, rast_color_input, rast_width, rast_height,
        input  read_rast_pixel_rdy
    );

    modport slave (
        input  rast_pixel_rdy, rast_color_input, rast_width, rast_height,
        output read_rast_pixel_rdy
    );
endinterface

// File: rtl/raster_pattern_source.sv
// Raster test-pattern generator: streams one frame of coordinates and colours per start,
// with ready/valid backpressure, end-of-frame pulse and buffer-swap request.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | pixel valid, advancing on each accepted transfer
// DONE   | one-cycle end-of-frame pulse
// SWITCH | one-cycle buffer-swap pulse, frame counter just advanced
module raster_pattern_source #(
    parameter  int H_RES    = 640,
    parameter  int V_RES    = 480,
    parameter  int COLOR_W  = 3,
    parameter  int BAR_LOG2 = 6,
    localparam int FW       = 8
) (
    input  logic                   clk_input,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   continuous,
    input  logic [1:0]             mode,
    input  logic [COLOR_W-1:0]     fill_color,
    raster_pattern_source_if.master pix,
    output logic                   rast_done,
    output logic                   next_frame_switch,
    output logic                   busy,
    output logic [FW-1:0]          frame_cnt
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE, SWITCH} state_t;

    state_t             state, n_state;
    logic [XW-1:0]      x, n_x;
    logic [YW-1:0]      y, n_y;
    logic [COLOR_W-1:0] color, n_color;
    logic [COLOR_W-1:0] fill_q, n_fill;
    logic [1:0]         mode_q, n_mode;
    logic [FW-1:0]      fc, n_fc;
    logic               rdy, n_rdy, done, n_done, sw, n_sw, busy_q, n_busy;
    logic               go;

    // Widened to 32 bits so bit BAR_LOG2 exists even when the coordinate is narrower.
    function automatic logic [COLOR_W-1:0] pattern(
        input logic [1:0]         m,
        input logic [COLOR_W-1:0] f,
        input logic [XW-1:0]      px,
        input logic [YW-1:0]      py,
        input logic [FW-1:0]      cnt
    );
        logic [31:0] xw, yw, cw;
        xw = 32'(px);
        yw = 32'(py);
        cw = 32'(cnt);
        case (m)
            2'd0:    pattern = f;
            2'd1:    pattern = COLOR_W'((xw >> BAR_LOG2) + cw);
            2'd2:    pattern = {COLOR_W{xw[BAR_LOG2] ^ yw[BAR_LOG2]}};
            default: pattern = COLOR_W'(xw + yw + cw);
        endcase
    endfunction

    always_comb begin
        n_state = state;
        n_x     = x;
        n_y     = y;
        n_color = color;
        n_fill  = fill_q;
        n_mode  = mode_q;
        n_fc    = fc;
        n_rdy   = rdy;
        n_done  = 1'b0;
        n_sw    = 1'b0;
        go      = 1'b0;
        case (state)
            IDLE: begin
                go = start && !abort;
            end
            STREAM: begin
                if (abort) begin
                    n_state = IDLE;
                    n_rdy   = 1'b0;
                end else if (pix.read_rast_pixel_rdy) begin
                    if (x == X_LAST && y == Y_LAST) begin
                        n_state = DONE;
                        n_rdy   = 1'b0;
                        n_done  = 1'b1;
                    end else begin
                        if (x == X_LAST) begin
                            n_x = '0;
                            n_y = y + YW'(1);
                        end else begin
                            n_x = x + XW'(1);
                        end
                        n_color = pattern(mode_q, fill_q, n_x, n_y, fc);
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    n_state = IDLE;
                end else begin
                    n_state = SWITCH;
                    n_sw    = 1'b1;
                    n_fc    = fc + FW'(1);
                end
            end
            default: begin
                if (continuous && !abort) go = 1'b1;
                else                      n_state = IDLE;
            end
        endcase
        // Frame entry: latch pattern controls; fc already holds the new count after SWITCH.
        if (go) begin
            n_state = STREAM;
            n_x     = '0;
            n_y     = '0;
            n_rdy   = 1'b1;
            n_mode  = mode;
            n_fill  = fill_color;
            n_color = pattern(mode, fill_color, '0, '0, fc);
        end
        n_busy = (n_state != IDLE);
    end

    always_ff @(posedge clk_input or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            color  <= '0;
            fill_q <= '0;
            mode_q <= '0;
            fc     <= '0;
            rdy    <= 1'b0;
            done   <= 1'b0;
            sw     <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= n_state;
            x      <= n_x;
            y      <= n_y;
            color  <= n_color;
            fill_q <= n_fill;
            mode_q <= n_mode;
            fc     <= n_fc;
            rdy    <= n_rdy;
            done   <= n_done;
            sw     <= n_sw;
            busy_q <= n_busy;
        end
    end

    assign pix.rast_pixel_rdy   = rdy;
    assign pix.rast_color_input = color;
    assign pix.rast_width       = x;
    assign pix.rast_height      = y;
    assign rast_done            = done;
    assign next_frame_switch    = sw;
    assign busy                 = busy_q;
    assign frame_cnt            = fc;
endmodule

// File: tb/tb_raster_pattern_source.sv
// Bench for raster_pattern_source at 4x2 pixels, 3-bit colour, 2-pixel bars/cells.
module tb_raster_pattern_source;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, continuous = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] fill = 3'd0;
    logic       rd = 1'b1;
    logic       toggle = 1'b0;
    logic       done, sw, busy;
    logic [7:0] fc;

    raster_pattern_source_if #(.COLOR_W(3), .XW(2), .YW(1)) pix();
    assign pix.read_rast_pixel_rdy = rd;

    raster_pattern_source #(.H_RES(4), .V_RES(2), .COLOR_W(3), .BAR_LOG2(1)) dut (
        .clk_input(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
        .mode(mode), .fill_color(fill), .pix(pix), .rast_done(done),
        .next_frame_switch(sw), .busy(busy), .frame_cnt(fc)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int q[$];
    int fc_model = 0;
    int done_cnt = 0, sw_cnt = 0;
    int held = 0;
    bit hold_pend = 1'b0;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle) rd = ~rd;
    endtask

    function automatic int model_color(int m, int f, int px, int py, int cnt);
        case (m)
            0:       return f;
            1:       return ((px >> 1) + cnt) % 8;
            2:       return ((((px >> 1) ^ (py >> 1)) & 1) != 0) ? 7 : 0;
            default: return (px + py + cnt) % 8;
        endcase
    endfunction

    task automatic push_frame(int m, int f, int cnt, int count);
        int k = 0;
        for (int py = 0; py < 2; py++)
            for (int px = 0; px < 4; px++) begin
                if (k < count) q.push_back((px << 8) | (py << 4) | model_color(m, f, px, py, cnt));
                k++;
            end
    endtask

    function automatic int cur_pixel();
        return (int'(pix.rast_width) << 8) | (int'(pix.rast_height) << 4) | int'(pix.rast_color_input);
    endfunction

    // Scoreboard: pop one expected pixel per accepted transfer; held pixels must not move.
    always @(negedge clk) begin
        int cur;
        cur = cur_pixel();
        if (pix.rast_pixel_rdy && hold_pend) check("hold_stable", cur, held);
        if (pix.rast_pixel_rdy && rd && !abort) begin
            if (q.size() == 0) check("unexpected_pixel", cur, -1);
            else check("pixel", cur, q.pop_front());
        end
        hold_pend = pix.rast_pixel_rdy && !rd && !abort;
        held = cur;
        if (done) done_cnt++;
        if (sw) sw_cnt++;
    end

    typedef struct {
        int m;
        int f;
        bit tog;
        bit hold_start;
        int exp_valid;
    } vec_t;

    task automatic run_frame(vec_t v);
        int valid = 0, n = 0;
        mode = 2'(v.m);
        fill = 3'(v.f);
        toggle = 1'b0;
        rd = 1'b1;
        push_frame(v.m, v.f, fc_model, 8);
        start = 1'b1;
        tick();
        if (!v.hold_start) start = 1'b0;
        mode = ~mode;
        fill = ~fill;
        check("start_latency", int'(pix.rast_pixel_rdy) * 256 + int'(pix.rast_width) * 16 + int'(pix.rast_height), 256);
        if (v.tog) begin
            toggle = 1'b1;
            rd = 1'b0;
        end
        while (!done && n < 100) begin
            if (pix.rast_pixel_rdy) valid++;
            tick();
            n++;
        end
        toggle = 1'b0;
        rd = 1'b1;
        start = 1'b0;
        check("done_timeout", int'(n < 100), 1);
        check("valid_cycles", valid, v.exp_valid);
        check("done_rdy_low", int'(pix.rast_pixel_rdy), 0);
        check("sb_drained", q.size(), 0);
        tick();
        check("switch_pulse", int'(sw) * 2 + int'(done), 2);
        check("frame_cnt", int'(fc), (fc_model + 1) % 256);
        fc_model++;
        tick();
        check("idle_after", int'(busy) * 2 + int'(sw), 0);
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{m: 0, f: 5, tog: 1'b0, hold_start: 1'b0, exp_valid: 8};
        vecs[1] = '{m: 1, f: 0, tog: 1'b1, hold_start: 1'b0, exp_valid: 16};
        vecs[2] = '{m: 2, f: 3, tog: 1'b0, hold_start: 1'b1, exp_valid: 8};
        vecs[3] = '{m: 3, f: 6, tog: 1'b0, hold_start: 1'b0, exp_valid: 8};
        vecs[4] = '{m: 1, f: 2, tog: 1'b1, hold_start: 1'b1, exp_valid: 16};

        #2;
        check("reset_state", int'({pix.rast_pixel_rdy, done, sw, busy, pix.rast_width, pix.rast_height,
                                   pix.rast_color_input, fc}), 0);
        #20 rst = 1'b0;

        foreach (vecs[i]) run_frame(vecs[i]);

        // start and abort together in IDLE: stay idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", int'(busy) * 2 + int'(pix.rast_pixel_rdy), 0);

        // Reset mid-frame at pixel (1,1)
        mode = 2'd3;
        rd = 1'b1;
        push_frame(3, 0, fc_model, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(pix.rast_width == 2'd1 && pix.rast_height == 1'b1) && n < 20) begin
            tick();
            n++;
        end
        check("reach_1_1", int'(n < 20), 1);
        rst = 1'b1;
        #1;
        check("rst_async", int'({pix.rast_pixel_rdy, done, sw, busy, pix.rast_width, pix.rast_height,
                                 pix.rast_color_input, fc}), 0);
        #2 rst = 1'b0;
        fc_model = 0;
        check("rst_sb_drained", q.size(), 0);

        // Continuous, mode 3, three frames; abort during the last SWITCH
        continuous = 1'b1;
        mode = 2'd3;
        rd = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(3, 0, fc_model + f, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("cont_start", int'(pix.rast_pixel_rdy) * 256 + int'(pix.rast_width) * 16 + int'(pix.rast_height), 256);
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (!done && n < 100) begin
                tick();
                n++;
            end
            check("cont_done_timeout", int'(n < 100), 1);
            check("cont_done_gap", int'(pix.rast_pixel_rdy), 0);
            tick();
            check("cont_switch", int'(sw) * 512 + int'(pix.rast_pixel_rdy) * 256 + int'(fc), 512 + fc_model + 1);
            fc_model++;
            if (f < 2) begin
                tick();
                check("cont_restart", int'(pix.rast_pixel_rdy) * 256 + int'(pix.rast_width) * 16
                                      + int'(pix.rast_height) * 8 + int'(pix.rast_color_input), 256 + fc_model);
            end else begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                continuous = 1'b0;
                check("switch_abort_idle", int'(busy) * 2 + int'(pix.rast_pixel_rdy), 0);
            end
        end
        check("cont_sb_drained", q.size(), 0);

        // Abort at pixel (2,0) with ready high
        mode = 2'd0;
        fill = 3'd1;
        rd = 1'b1;
        push_frame(0, 1, fc_model, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(pix.rast_width == 2'd2 && pix.rast_height == 1'b0) && n < 20) begin
            tick();
            n++;
        end
        check("reach_2_0", int'(n < 20), 1);
        abort = 1'b1;
        n = done_cnt + sw_cnt;
        tick();
        abort = 1'b0;
        check("abort_idle", int'(busy) * 2 + int'(pix.rast_pixel_rdy), 0);
        repeat (4) tick();
        check("abort_no_pulses", done_cnt + sw_cnt, n);
        check("abort_frame_cnt", int'(fc), fc_model);
        check("abort_sb_drained", q.size(), 0);

        // Normal frame after abort starts cleanly at (0,0)
        run_frame(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
